loop_break_ctrl: RTL and testbench

//  Synthesizable counterpart of a named forever/for loop with `disable` (break).

---
 rtl/loop_break_if.sv | 39 +++
 rtl/loop_break_ctrl.sv | 110 +++++++++++
 tb/tb_loop_break_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/loop_break_if.sv
// loop_break_if
//   Bundles the start/break request side and the status/result side of the
//   loop_break_ctrl block.
//   master: drives start_i, count_i, forever_i, break_i; observes the status outputs.
//   slave : the controller; drives busy_o, done_o, broken_o, iter_o, o.
//   Signals:
//     start_i   start a loop (sampled in IDLE only)
//     count_i   iteration bound, latched at start
//     forever_i 1 = ignore count and run until break; latched at start
//     break_i   disable request, honoured only while running
//     busy_o    high while the loop body runs
//     done_o    one-cycle completion pulse
//     broken_o  last loop was ended by break; held until the next start
//     iter_o    completed iterations of the current/last loop
//     o         loop result register
interface loop_break_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             start_i;
  logic [CNT_W-1:0] count_i;
  logic             forever_i;
  logic             break_i;
  logic             busy_o;
  logic             done_o;
  logic             broken_o;
  logic [CNT_W-1:0] iter_o;
  logic [WIDTH-1:0] o;

  modport master (
    output start_i, count_i, forever_i, break_i,
    input  busy_o, done_o, broken_o, iter_o, o
  );

  modport slave (
    input  start_i, count_i, forever_i, break_i,
    output busy_o, done_o, broken_o, iter_o, o
  );
endinterface

// File: rtl/loop_break_ctrl.sv
// loop_break_ctrl
//   Hardware form of a named forever/for loop with a break. On start it
//   reloads o with INIT_VAL and then adds STEP to o once per cycle until the
//   latched iteration bound is reached or a break request arrives. It
//   reports whether the loop completed normally or was broken.
//   Ports:
//     clk  clock, all state on the rising edge
//     rst  asynchronous active-high reset
//     bus  loop_break_if.slave: start/count/forever/break in,
//          busy/done/broken/iter/o out (all outputs registered)
module loop_break_ctrl #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 8,
  parameter int INIT_VAL = 1,
  parameter int STEP     = 10
) (
  input  logic             clk,
  input  logic             rst,
  loop_break_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             forever_q, forever_n;
  logic [WIDTH-1:0] o_q, o_n;
  logic [CNT_W-1:0] iter_q, iter_n;
  logic             broken_q, broken_n;
  logic             busy_q, done_q;

  // One extra bit so that a bound of 2^CNT_W-1 is reached without the
  // incremented count wrapping back to zero.
  logic [CNT_W:0]   iter_inc;
  assign iter_inc = {1'b0, iter_q} + (CNT_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count_q   <= '0;
      forever_q <= 1'b0;
      o_q       <= WIDTH'(INIT_VAL);
      iter_q    <= '0;
      broken_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      count_q   <= count_n;
      forever_q <= forever_n;
      o_q       <= o_n;
      iter_q    <= iter_n;
      broken_q  <= broken_n;
      // Status flags are registered views of the state being entered.
      busy_q    <= (state_n == RUN);
      done_q    <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count_q;
    forever_n = forever_q;
    o_n       = o_q;
    iter_n    = iter_q;
    broken_n  = broken_q;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          count_n   = bus.count_i;
          forever_n = bus.forever_i;
          o_n       = WIDTH'(INIT_VAL);
          iter_n    = '0;
          broken_n  = 1'b0;
          if (!bus.forever_i && (bus.count_i == '0)) state_n = DONE;
          else                                       state_n = RUN;
        end
      end
      RUN: begin
        // Break wins over the body update, including on the final iteration.
        if (bus.break_i) begin
          broken_n = 1'b1;
          state_n  = DONE;
        end else begin
          o_n    = o_q + WIDTH'(STEP);
          iter_n = iter_q + CNT_W'(1);
          if (!forever_q && (iter_inc == {1'b0, count_q})) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.broken_o = broken_q;
  assign bus.iter_o   = iter_q;
  assign bus.o        = o_q;

endmodule

// File: tb/tb_loop_break_ctrl.sv
// tb_loop_break_ctrl
//   Table of loop transactions with hand-derived results; each expected
//   result is queued when the start is driven and checked when done_o fires.
//   Hand-written sequences cover reset, mid-loop reset and IDLE break.
module tb_loop_break_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  loop_break_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  loop_break_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .INIT_VAL(1), .STEP(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] o;
    int          iter;
    bit          broken;
    int          busy;
  } exp_t;

  typedef struct {
    int   cnt;
    bit   fv;
    int   brk;   // RUN cycle (1-based) on which break_i is high, 0 = none
    int   mid;   // RUN cycle on which a stray start_i is pulsed, 0 = none
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  bit   done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard side: count busy cycles, compare the queued result on done_o.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        check("done_width", done_prev, 0);
        check("done_busy_overlap", bus.busy_o, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("o", bus.o, e.o);
          check("iter", bus.iter_o, e.iter);
          check("broken", bus.broken_o, e.broken);
          check("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
      done_prev = bus.done_o;
    end
  end

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic run_txn(input int cnt, input bit fv, input int brk, input int mid, input exp_t e);
    int cyc;
    exp_q.push_back(e);
    bus.start_i   = 1'b1;
    bus.count_i   = CNT_W'(cnt);
    bus.forever_i = fv;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    bus.count_i   = '0;
    bus.forever_i = 1'b0;
    cyc = 1;
    while (!bus.done_o && cyc < 1000) begin
      bus.break_i = (cyc == brk);
      if (cyc == mid) begin
        bus.start_i   = 1'b1;
        bus.count_i   = 8'd200;
        bus.forever_i = 1'b1;
      end
      @(posedge clk); #1;
      bus.break_i   = 1'b0;
      bus.start_i   = 1'b0;
      bus.count_i   = '0;
      bus.forever_i = 1'b0;
      cyc++;
    end
    if (!bus.done_o) check("txn_timeout", 1, 0);
    @(posedge clk); #1;
    check("idle_after_done", {bus.busy_o, bus.done_o}, 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{3,   0, 0,   0, '{32'd31,   3,   1'b0, 3}};
    vecs[1] = '{0,   1, 6,   0, '{32'd51,   5,   1'b1, 6}};
    vecs[2] = '{0,   0, 0,   0, '{32'd1,    0,   1'b0, 0}};
    vecs[3] = '{4,   0, 4,   0, '{32'd31,   3,   1'b1, 4}};
    vecs[4] = '{1,   0, 0,   0, '{32'd11,   1,   1'b0, 1}};
    vecs[5] = '{255, 0, 0,   0, '{32'd2551, 255, 1'b0, 255}};
    vecs[6] = '{7,   1, 300, 0, '{32'd2991, 43,  1'b1, 300}};
    vecs[7] = '{5,   0, 1,   0, '{32'd1,    0,   1'b1, 1}};
    vecs[8] = '{3,   0, 0,   2, '{32'd31,   3,   1'b0, 3}};

    bus.start_i   = 1'b0;
    bus.count_i   = '0;
    bus.forever_i = 1'b0;
    bus.break_i   = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_o", bus.o, 1);
    check("rst_iter", bus.iter_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_broken", bus.broken_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].cnt, vecs[i].fv, vecs[i].brk, vecs[i].mid, vecs[i].e);

    // Reset in the middle of a loop: immediate return, no done pulse.
    bus.start_i = 1'b1;
    bus.count_i = 8'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.count_i = '0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_iter", bus.iter_o, 2);
    check("mid_o", bus.o, 21);
    check("mid_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    check("arst_o", bus.o, 1);
    check("arst_iter", bus.iter_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_done", bus.done_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("post_rst_busy", bus.busy_o, 0);
    run_txn(2, 0, 0, 0, '{32'd21, 2, 1'b0, 2});

    // Break in IDLE must not start or mark anything.
    bus.break_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.break_i = 1'b0;
    check("idle_brk_broken", bus.broken_o, 0);
    check("idle_brk_o", bus.o, 21);
    check("idle_brk_busy", bus.busy_o, 0);
    @(posedge clk); #1;

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
